// File: rtl/cci_mmio_initiator_if.sv
// Command, MMIO request/response and tagged-response signals of the CCI MMIO initiator.
interface cci_mmio_initiator_if #(
  parameter int unsigned TAG_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_is_write;
  logic                 cmd_len8;
  logic [15:0]          cmd_addr;
  logic [63:0]          cmd_data;
  logic [TAG_WIDTH-1:0] cmd_tag;

  logic                 mmio_rd_valid;
  logic                 mmio_wr_valid;
  logic [15:0]          mmio_addr;
  logic                 mmio_len8;
  logic [8:0]           mmio_tid;
  logic [63:0]          mmio_data;

  logic                 mmio_rsp_valid;
  logic [8:0]           mmio_rsp_tid;
  logic [63:0]          mmio_rsp_data;

  logic                 rsp_valid;
  logic [TAG_WIDTH-1:0] rsp_tag;
  logic [63:0]          rsp_data;
  logic                 rsp_timeout;
  logic [6:0]           outstanding;
  logic                 err_spurious;
  logic                 err_misaligned;

  modport master (
    input  cmd_valid, cmd_is_write, cmd_len8, cmd_addr, cmd_data, cmd_tag,
    input  mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data,
    output cmd_ready,
    output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len8, mmio_tid, mmio_data,
    output rsp_valid, rsp_tag, rsp_data, rsp_timeout, outstanding,
    output err_spurious, err_misaligned
  );

  modport slave (
    output cmd_valid, cmd_is_write, cmd_len8, cmd_addr, cmd_data, cmd_tag,
    output mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data,
    input  cmd_ready,
    input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len8, mmio_tid, mmio_data,
    input  rsp_valid, rsp_tag, rsp_data, rsp_timeout, outstanding,
    input  err_spurious, err_misaligned
  );
endinterface

// File: rtl/cci_mmio_initiator.sv
// CCI MMIO requester: turns tagged commands into MMIO request beats and returns tagged read responses.
// Read timeout retirement is compiled in with CCI_MMIO_INIT_TIMEOUT_EN.
module cci_mmio_initiator #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TAG_WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter int unsigned ISSUE_GAP       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  cci_mmio_initiator_if.master io_bus
);
  localparam int unsigned L  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned SW = 9 - L;
  localparam int unsigned GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
  localparam int unsigned CW = 7;

  logic [MAX_OUTSTANDING-1:0] r_busy;
  logic [TAG_WIDTH-1:0]       r_tag [MAX_OUTSTANDING];
  logic [SW-1:0]              r_seq [MAX_OUTSTANDING];
  logic [SW-1:0]              r_seq_cnt;
  logic [GW-1:0]              r_gap;
  logic [CW-1:0]              r_outstanding;

  logic                       r_rd_valid;
  logic                       r_wr_valid;
  logic [15:0]                r_addr;
  logic                       r_len8;
  logic [8:0]                 r_tid;
  logic [63:0]                r_data;
  logic                       r_rsp_valid;
  logic [TAG_WIDTH-1:0]       r_rsp_tag;
  logic [63:0]                r_rsp_data;
  logic                       r_rsp_timeout;
  logic                       r_err_spurious;
  logic                       r_err_misaligned;

  logic                       w_cmd_ready;
  logic                       w_accept;
  logic                       w_misaligned;
  logic                       w_issue_rd;
  logic                       w_issue_wr;
  logic                       w_match;
  logic                       w_retire_to;
  logic [L-1:0]               w_free_idx;
  logic [L-1:0]               w_rsp_slot;
  logic [L-1:0]               w_to_idx;
  logic [SW-1:0]              w_rsp_seq;

  assign w_cmd_ready  = !reset && !(&r_busy) && (r_gap == '0);
  assign w_accept     = io_bus.cmd_valid && w_cmd_ready;
  assign w_misaligned = io_bus.cmd_len8 && io_bus.cmd_addr[0];
  assign w_issue_rd   = w_accept && !w_misaligned && !io_bus.cmd_is_write;
  assign w_issue_wr   = w_accept && !w_misaligned &&  io_bus.cmd_is_write;

  // Response TID carries the slot in its low bits and the allocation sequence above it.
  assign w_rsp_slot = io_bus.mmio_rsp_tid[L-1:0];
  assign w_rsp_seq  = io_bus.mmio_rsp_tid[8:L];
  assign w_match    = io_bus.mmio_rsp_valid && r_busy[w_rsp_slot] &&
                      (r_seq[w_rsp_slot] == w_rsp_seq);

  // Lowest free slot index.
  always_comb begin
    w_free_idx = '0;
    for (int i = int'(MAX_OUTSTANDING) - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = L'(i);
    end
  end

`ifdef CCI_MMIO_INIT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0]              r_timer [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] w_expired;

  // Expired slots hold their timer until retired; lowest index retires first.
  always_comb begin
    w_expired = '0;
    w_to_idx  = '0;
    for (int i = int'(MAX_OUTSTANDING) - 1; i >= 0; i--) begin
      w_expired[i] = r_busy[i] && (r_timer[i] == TW'(TIMEOUT_CYCLES - 1));
      if (w_expired[i]) w_to_idx = L'(i);
    end
  end

  // A matching response owns the output this cycle; timeouts wait one cycle.
  assign w_retire_to = (|w_expired) && !w_match;

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      if (reset) begin
        r_timer[i] <= '0;
      end else if (w_issue_rd && (w_free_idx == L'(i))) begin
        r_timer[i] <= '0;
      end else if (r_busy[i] && (r_timer[i] != TW'(TIMEOUT_CYCLES - 1))) begin
        r_timer[i] <= r_timer[i] + TW'(1);
      end
    end
  end
`else
  assign w_to_idx    = '0;
  assign w_retire_to = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy           <= '0;
      r_seq_cnt        <= '0;
      r_gap            <= '0;
      r_outstanding    <= '0;
      r_rd_valid       <= 1'b0;
      r_wr_valid       <= 1'b0;
      r_addr           <= '0;
      r_len8           <= 1'b0;
      r_tid            <= '0;
      r_data           <= '0;
      r_rsp_valid      <= 1'b0;
      r_rsp_tag        <= '0;
      r_rsp_data       <= '0;
      r_rsp_timeout    <= 1'b0;
      r_err_spurious   <= 1'b0;
      r_err_misaligned <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        r_tag[i] <= '0;
        r_seq[i] <= '0;
      end
    end else begin
      r_rd_valid <= w_issue_rd;
      r_wr_valid <= w_issue_wr;
      if (w_issue_rd || w_issue_wr) begin
        r_addr <= io_bus.cmd_addr;
        r_len8 <= io_bus.cmd_len8;
        r_tid  <= w_issue_rd ? {r_seq_cnt, w_free_idx} : 9'd0;
        r_data <= w_issue_wr ? io_bus.cmd_data : 64'd0;
        r_gap  <= GW'(ISSUE_GAP);
      end else if (r_gap != '0) begin
        r_gap <= r_gap - GW'(1);
      end
      if (w_issue_rd) r_seq_cnt <= r_seq_cnt + SW'(1);

      // Allocation only targets free slots and retirement only busy ones, so they never collide.
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (w_issue_rd && (w_free_idx == L'(i))) begin
          r_busy[i] <= 1'b1;
          r_tag[i]  <= io_bus.cmd_tag;
          r_seq[i]  <= r_seq_cnt;
        end else if ((w_match && (w_rsp_slot == L'(i))) ||
                     (w_retire_to && (w_to_idx == L'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end

      r_rsp_valid   <= w_match || w_retire_to;
      r_rsp_timeout <= w_retire_to;
      r_rsp_tag     <= w_match ? r_tag[w_rsp_slot] : r_tag[w_to_idx];
      r_rsp_data    <= w_match ? io_bus.mmio_rsp_data : 64'd0;
      r_outstanding <= r_outstanding + CW'(w_issue_rd) - CW'(w_match || w_retire_to);

      if (io_bus.mmio_rsp_valid && !w_match) r_err_spurious   <= 1'b1;
      if (w_accept && w_misaligned)          r_err_misaligned <= 1'b1;
    end
  end

  assign io_bus.cmd_ready      = w_cmd_ready;
  assign io_bus.mmio_rd_valid  = r_rd_valid;
  assign io_bus.mmio_wr_valid  = r_wr_valid;
  assign io_bus.mmio_addr      = r_addr;
  assign io_bus.mmio_len8      = r_len8;
  assign io_bus.mmio_tid       = r_tid;
  assign io_bus.mmio_data      = r_data;
  assign io_bus.rsp_valid      = r_rsp_valid;
  assign io_bus.rsp_tag        = r_rsp_tag;
  assign io_bus.rsp_data       = r_rsp_data;
  assign io_bus.rsp_timeout    = r_rsp_timeout;
  assign io_bus.outstanding    = r_outstanding;
  assign io_bus.err_spurious   = r_err_spurious;
  assign io_bus.err_misaligned = r_err_misaligned;
endmodule

// File: tb/tb_cci_mmio_initiator.sv
// Self-checking bench for cci_mmio_initiator; expected tagged responses are queued and popped by a monitor.
module tb_cci_mmio_initiator;
  typedef struct packed {
    logic [7:0]  tag;
    logic [63:0] data;
    logic        to;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t e;

  cci_mmio_initiator_if #(.TAG_WIDTH(8)) bus ();

  cci_mmio_initiator #(
    .MAX_OUTSTANDING(4),
    .TAG_WIDTH      (8),
    .TIMEOUT_CYCLES (16),
    .ISSUE_GAP      (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every tagged response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp got tag=%h data=%h to=%b", bus.rsp_tag, bus.rsp_data, bus.rsp_timeout);
      end else begin
        e = sb.pop_front();
        if ({bus.rsp_tag, bus.rsp_data, bus.rsp_timeout} !== e) begin
          n_fail++;
          $display("FAIL rsp_payload got tag=%h data=%h to=%b exp tag=%h data=%h to=%b",
                   bus.rsp_tag, bus.rsp_data, bus.rsp_timeout, e.tag, e.data, e.to);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Presents one command for a single edge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic w, input logic l8, input logic [15:0] a,
                       input logic [63:0] d, input logic [7:0] t);
    bus.cmd_valid    = 1'b1;
    bus.cmd_is_write = w;
    bus.cmd_len8     = l8;
    bus.cmd_addr     = a;
    bus.cmd_data     = d;
    bus.cmd_tag      = t;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic afu_rsp(input logic [8:0] tid, input logic [63:0] d);
    bus.mmio_rsp_valid = 1'b1;
    bus.mmio_rsp_tid   = tid;
    bus.mmio_rsp_data  = d;
    @(posedge clk);
    #1 bus.mmio_rsp_valid = 1'b0;
  endtask

  task automatic check_drained(input string name);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain pending=%0d exp=0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=0", bus.cmd_ready); end
    n_tests++;
    if ({bus.mmio_rd_valid, bus.mmio_wr_valid, bus.rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valids got=%b exp=000", {bus.mmio_rd_valid, bus.mmio_wr_valid, bus.rsp_valid});
    end
    n_tests++;
    if (bus.outstanding !== 7'd0) begin n_fail++; $display("FAIL reset_outstanding got=%0d exp=0", bus.outstanding); end
    n_tests++;
    if ({bus.err_spurious, bus.err_misaligned} !== 2'b00) begin
      n_fail++; $display("FAIL reset_errs got=%b exp=00", {bus.err_spurious, bus.err_misaligned});
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_single_read();
    do_reset();
    issue(1'b0, 1'b1, 16'h0002, 64'h0, 8'h5A);
    n_tests++;
    if ({bus.mmio_rd_valid, bus.mmio_wr_valid, bus.mmio_tid, bus.mmio_addr, bus.mmio_len8, bus.mmio_data}
        !== {1'b1, 1'b0, 9'h000, 16'h0002, 1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL single_req got rd=%b wr=%b tid=%h addr=%h len8=%b data=%h exp rd=1 wr=0 tid=000 addr=0002 len8=1 data=0",
               bus.mmio_rd_valid, bus.mmio_wr_valid, bus.mmio_tid, bus.mmio_addr, bus.mmio_len8, bus.mmio_data);
    end
    n_tests++;
    if (bus.outstanding !== 7'd1) begin n_fail++; $display("FAIL single_out1 got=%0d exp=1", bus.outstanding); end
    sb.push_back('{tag: 8'h5A, data: 64'h438d6c19, to: 1'b0});
    afu_rsp(9'h000, 64'h438d6c19);
    n_tests++;
    if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got=%b exp=1", bus.rsp_valid); end
    n_tests++;
    if (bus.outstanding !== 7'd0) begin n_fail++; $display("FAIL single_out0 got=%0d exp=0", bus.outstanding); end
    check_drained("single");
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_tid [4] = '{9'h000, 9'h005, 9'h00A, 9'h00F};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b0, 16'h0100 + 16'(i), 64'h0, 8'h10 + 8'(i));
      n_tests++;
      if (bus.mmio_rd_valid !== 1'b1 || bus.mmio_tid !== exp_tid[i]) begin
        n_fail++;
        $display("FAIL b2b_tid[%0d] got rd=%b tid=%h exp rd=1 tid=%h", i, bus.mmio_rd_valid, bus.mmio_tid, exp_tid[i]);
      end
    end
    n_tests++;
    if (bus.outstanding !== 7'd4 || bus.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full got out=%0d ready=%b exp out=4 ready=0", bus.outstanding, bus.cmd_ready);
    end
    sb.push_back('{tag: 8'h12, data: 64'hA5A5_0000_1111_2222, to: 1'b0});
    afu_rsp(9'h00A, 64'hA5A5_0000_1111_2222);
    n_tests++;
    if (bus.outstanding !== 7'd3 || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_free got out=%0d ready=%b exp out=3 ready=1", bus.outstanding, bus.cmd_ready);
    end
    issue(1'b0, 1'b0, 16'h0200, 64'h0, 8'h20);
    n_tests++;
    if (bus.mmio_tid !== 9'h012) begin n_fail++; $display("FAIL b2b_realloc_tid got=%h exp=012", bus.mmio_tid); end
    // Drain out of order, one response per cycle.
    sb.push_back('{tag: 8'h13, data: 64'h3, to: 1'b0});
    afu_rsp(9'h00F, 64'h3);
    sb.push_back('{tag: 8'h10, data: 64'h0, to: 1'b0});
    afu_rsp(9'h000, 64'h0);
    sb.push_back('{tag: 8'h20, data: 64'hFFFF_FFFF_FFFF_FFFF, to: 1'b0});
    afu_rsp(9'h012, 64'hFFFF_FFFF_FFFF_FFFF);
    sb.push_back('{tag: 8'h11, data: 64'h1, to: 1'b0});
    afu_rsp(9'h005, 64'h1);
    n_tests++;
    if (bus.outstanding !== 7'd0) begin n_fail++; $display("FAIL b2b_out0 got=%0d exp=0", bus.outstanding); end
    check_drained("b2b");
  endtask

  task automatic test_write_misaligned();
    do_reset();
    issue(1'b1, 1'b1, 16'h0041, 64'h1234, 8'h01);
    n_tests++;
    if ({bus.mmio_rd_valid, bus.mmio_wr_valid, bus.err_misaligned} !== 3'b001) begin
      n_fail++; $display("FAIL misalign_wr got rd=%b wr=%b err=%b exp rd=0 wr=0 err=1",
                         bus.mmio_rd_valid, bus.mmio_wr_valid, bus.err_misaligned);
    end
    issue(1'b1, 1'b1, 16'h0040, 64'hDEADBEEF, 8'h02);
    n_tests++;
    if ({bus.mmio_rd_valid, bus.mmio_wr_valid, bus.mmio_tid, bus.mmio_addr, bus.mmio_data}
        !== {1'b0, 1'b1, 9'h000, 16'h0040, 64'hDEADBEEF}) begin
      n_fail++; $display("FAIL write_req got rd=%b wr=%b tid=%h addr=%h data=%h exp rd=0 wr=1 tid=000 addr=0040 data=deadbeef",
                         bus.mmio_rd_valid, bus.mmio_wr_valid, bus.mmio_tid, bus.mmio_addr, bus.mmio_data);
    end
    n_tests++;
    if (bus.outstanding !== 7'd0) begin n_fail++; $display("FAIL write_out got=%0d exp=0", bus.outstanding); end
    issue(1'b0, 1'b1, 16'h0003, 64'h0, 8'h03);
    n_tests++;
    if ({bus.mmio_rd_valid, bus.mmio_wr_valid, bus.outstanding} !== {2'b00, 7'd0}) begin
      n_fail++; $display("FAIL misalign_rd got rd=%b wr=%b out=%0d exp rd=0 wr=0 out=0",
                         bus.mmio_rd_valid, bus.mmio_wr_valid, bus.outstanding);
    end
    check_drained("write");
  endtask

  task automatic test_spurious();
    do_reset();
    afu_rsp(9'h1F3, 64'h77);
    n_tests++;
    if ({bus.rsp_valid, bus.err_spurious} !== 2'b01) begin
      n_fail++; $display("FAIL spurious_idle got rsp=%b err=%b exp rsp=0 err=1", bus.rsp_valid, bus.err_spurious);
    end
    do_reset();
    issue(1'b0, 1'b0, 16'h0010, 64'h0, 8'h44);
    afu_rsp(9'h004, 64'h55);
    n_tests++;
    if ({bus.rsp_valid, bus.err_spurious, bus.outstanding} !== {2'b01, 7'd1}) begin
      n_fail++; $display("FAIL spurious_seq got rsp=%b err=%b out=%0d exp rsp=0 err=1 out=1",
                         bus.rsp_valid, bus.err_spurious, bus.outstanding);
    end
    sb.push_back('{tag: 8'h44, data: 64'h66, to: 1'b0});
    afu_rsp(9'h000, 64'h66);
    check_drained("spurious");
  endtask

`ifdef CCI_MMIO_INIT_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    issue(1'b0, 1'b0, 16'h0020, 64'h0, 8'h11);
    sb.push_back('{tag: 8'h11, data: 64'h0, to: 1'b1});
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid !== 1'b0) begin
        n_tests++; n_fail++; $display("FAIL timeout_early cycle=%0d got rsp=1 exp rsp=0", k);
      end
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_tag, bus.rsp_data} !== {1'b1, 1'b1, 8'h11, 64'h0}) begin
      n_fail++; $display("FAIL timeout_retire got v=%b to=%b tag=%h data=%h exp v=1 to=1 tag=11 data=0",
                         bus.rsp_valid, bus.rsp_timeout, bus.rsp_tag, bus.rsp_data);
    end
    n_tests++;
    if (bus.outstanding !== 7'd0) begin n_fail++; $display("FAIL timeout_out got=%0d exp=0", bus.outstanding); end
    afu_rsp(9'h000, 64'h99);
    n_tests++;
    if (bus.err_spurious !== 1'b1) begin n_fail++; $display("FAIL timeout_late got err=%b exp=1", bus.err_spurious); end
    check_drained("timeout");
  endtask

  task automatic test_timeout_race();
    do_reset();
    issue(1'b0, 1'b0, 16'h0030, 64'h0, 8'h21);
    issue(1'b0, 1'b0, 16'h0031, 64'h0, 8'h22);
    sb.push_back('{tag: 8'h22, data: 64'hCAFE, to: 1'b0});
    sb.push_back('{tag: 8'h21, data: 64'h0,    to: 1'b1});
    repeat (14) @(posedge clk);
    #1;
    afu_rsp(9'h005, 64'hCAFE);
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_tag} !== {2'b10, 8'h22}) begin
      n_fail++; $display("FAIL race_first got v=%b to=%b tag=%h exp v=1 to=0 tag=22",
                         bus.rsp_valid, bus.rsp_timeout, bus.rsp_tag);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_tag} !== {2'b11, 8'h21}) begin
      n_fail++; $display("FAIL race_second got v=%b to=%b tag=%h exp v=1 to=1 tag=21",
                         bus.rsp_valid, bus.rsp_timeout, bus.rsp_tag);
    end
    check_drained("race");
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) issue(1'b0, 1'b0, 16'h0050 + 16'(i), 64'h0, 8'h30 + 8'(i));
    n_tests++;
    if (bus.outstanding !== 7'd3) begin n_fail++; $display("FAIL rstmid_out3 got=%0d exp=3", bus.outstanding); end
    do_reset();
    afu_rsp(9'h000, 64'h1);
    afu_rsp(9'h005, 64'h2);
    afu_rsp(9'h00A, 64'h3);
    n_tests++;
    if ({bus.outstanding, bus.err_spurious} !== {7'd0, 1'b1}) begin
      n_fail++; $display("FAIL rstmid got out=%0d err=%b exp out=0 err=1", bus.outstanding, bus.err_spurious);
    end
    check_drained("rstmid");
  endtask

  initial begin
    reset              = 1'b1;
    bus.cmd_valid      = 1'b0;
    bus.cmd_is_write   = 1'b0;
    bus.cmd_len8       = 1'b0;
    bus.cmd_addr       = '0;
    bus.cmd_data       = '0;
    bus.cmd_tag        = '0;
    bus.mmio_rsp_valid = 1'b0;
    bus.mmio_rsp_tid   = '0;
    bus.mmio_rsp_data  = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_misaligned();
    test_spurious();
`ifdef CCI_MMIO_INIT_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
